rv_plic_claim_agent: RTL and testbench
======================================

// Module: rv_plic_claim_agent
// PURPOSE
//  Target-side (hart-side) end of the PLIC claim/complete protocol. It watches one target's irq/irq_id
//  notification and performs the claim read of that target's CC register as a TL-UL host.
//  It hands the claimed ID to the core, waits for the handler to finish, then writes the ID back to CC (complete).
//  Sits between rv_plic (irq_o[t]/irq_id_o[t], TL-UL device port via xbar) and a core's interrupt sideband.
// PARAMETERS
//  CC_ADDR   32'h0C20_0004  byte address of this target's CC (claim/complete) register
//  ID_W      7              interrupt ID width (= SRCW+1 of the PLIC, NumSrc=64)
//  TL_SRC    0              a_source value used on all requests
// PORTS
//  clk_i       in   1                  clock
//  rst_i       in   1                  reset, asynchronous, active-high
//  en_i        in   1                  1: new claims allowed; 0: finish current sequence, then stay IDLE
//  irq_i       in   1                  PLIC irq_o[t] (registered in PLIC)
//  irq_id_i    in   ID_W               PLIC irq_id_o[t], debug/compare only, not used for claim
//  tl_o        out  tl_h2d_t           TL-UL host request channel A + d_ready
//  tl_i        in   tl_d2h_t           TL-UL device response channel D + a_ready
//  int_valid_o out  1                  claimed interrupt presented to core
//  int_id_o    out  ID_W               claimed ID, valid while int_valid_o
//  int_ready_i in   1                  core accepts ID (valid&ready handshake)
//  int_done_i  in   1                  handler finished pulse; sampled only in SERVICE
//  busy_o      out  1                  state != IDLE
//  err_o       out  1                  sticky: TL d_error seen on claim or complete
//  err_clr_i   in   1                  clears err_o (err set has priority in same cycle)
// BEHAVIOUR
//  Reset: state=IDLE, id_q=0, err_o=0, all tl_o fields 0, int_valid_o=0, busy_o=0; async assert, sync deassert.
//  One outstanding TL transaction max. Unused A fields (a_param, a_user) = 0; a_size=2, a_mask=4'hF, a_source=TL_SRC.
//  a_valid and all A fields held stable from rise until a_ready; d_ready=1 only in CLAIM_RSP/COMPL_RSP.
//  FSM (registered state; outputs decoded from state/id_q, no comb path from inputs to a_valid):
//   IDLE:      en_i & irq_i -> CLAIM_REQ (next cycle a_valid=1). Else stay.
//   CLAIM_REQ: a_opcode=Get, a_address=CC_ADDR. a_valid&a_ready -> CLAIM_RSP.
//   CLAIM_RSP: wait d_valid. d_error -> set err, IDLE. Else id_q<=d_data[ID_W-1:0];
//              id==0 (spurious / already claimed by another target) -> IDLE, no complete issued; else DELIVER.
//   DELIVER:   int_valid_o=1, int_id_o=id_q. int_ready_i -> SERVICE.
//   SERVICE:   wait int_done_i (done in DELIVER cycle ignored) -> COMPL_REQ.
//   COMPL_REQ: a_opcode=PutFullData, a_address=CC_ADDR, a_data={'0,id_q}. a_valid&a_ready -> COMPL_RSP.
//   COMPL_RSP: wait d_valid. d_error -> set err. Either way -> IDLE.
//  Min latency irq_i rise -> int_valid_o: 3 cycles with a_ready=1 and 1-cycle D response.
//  Back-to-back: IDLE re-samples irq_i the cycle after COMPL_RSP; stale irq_i yields ID 0 claim -> harmless.
//  en_i drop mid-sequence does not abort; sequence completes, then IDLE holds.
//  irq_i drop after leaving IDLE ignored; claim still issued (PLIC returns 0 if nothing pending).
//  d_valid outside *_RSP not accepted (d_ready=0); cannot occur with one outstanding.
//  Reset mid-sequence abandons it; an un-completed claim remains open in the PLIC gateway (system-level
//   recovery by software re-complete); agent does not replay.
//  err_o: set on d_error; cleared by err_clr_i; never affects FSM progress beyond stated transitions.
// TESTING
//  1 irq_i=1, D returns 0x2A, ready/done after 5 cyc -> Get @CC_ADDR, int_id_o=0x2A, PutFullData data=0x2A, IDLE.
//  2 Claim returns 0 -> no int_valid_o, no write, IDLE next cycle after d_valid.
//  3 a_ready held 0 for 10 cycles in CLAIM_REQ and COMPL_REQ -> A fields bit-stable, single handshake each.
//  4 d_error=1 on claim -> err_o=1, IDLE, no DELIVER; err_clr_i pulse -> err_o=0; simultaneous set+clr -> 1.
//  5 en_i=0 during SERVICE -> complete still issued; with irq_i=1 stays IDLE until en_i=1.
//  6 rst_i asserted in SERVICE -> outputs zero same cycle (async), state IDLE, next irq_i triggers fresh claim.

Source files
------------

// File: rtl/rv_plic_claim_agent_if.sv
// TL-UL channel types and the host<->device bundle used by the PLIC claim agent.
// The bundle keeps the channel names tl_o (host to device) and tl_i (device to host).
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

interface rv_plic_claim_agent_if;
  import tlul_pkg::*;

  tl_h2d_t tl_o;
  tl_d2h_t tl_i;

  modport master (output tl_o, input tl_i);
  modport slave  (input tl_o, output tl_i);
endinterface

// File: rtl/rv_plic_claim_agent.sv
// Hart-side PLIC claim/complete agent: reads CC to claim, hands the ID to the core,
// then writes the same ID back to CC once the handler reports completion.
module rv_plic_claim_agent
  import tlul_pkg::*;
#(
  parameter logic [31:0] CC_ADDR = 32'h0C20_0004,
  parameter int unsigned ID_W    = 7,
  parameter logic [7:0]  TL_SRC  = 8'd0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   irq_i,
  input  logic [ID_W-1:0]        irq_id_i,
  rv_plic_claim_agent_if.master  tl,
  output logic                   int_valid_o,
  output logic [ID_W-1:0]        int_id_o,
  input  logic                   int_ready_i,
  input  logic                   int_done_i,
  output logic                   busy_o,
  output logic                   err_o,
  input  logic                   err_clr_i
);

  typedef enum logic [2:0] {
    IDLE,
    CLAIM_REQ,
    CLAIM_RSP,
    DELIVER,
    SERVICE,
    COMPL_REQ,
    COMPL_RSP
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            err_q, err_d;
  logic            err_set;
  tl_h2d_t         tl_h2d;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    err_set = 1'b0;
    unique case (state_q)
      IDLE:      if (en_i && irq_i) state_d = CLAIM_REQ;
      CLAIM_REQ: if (tl.tl_i.a_ready) state_d = CLAIM_RSP;
      CLAIM_RSP: begin
        if (tl.tl_i.d_valid) begin
          if (tl.tl_i.d_error) begin
            err_set = 1'b1;
            state_d = IDLE;
          end else begin
            id_d    = tl.tl_i.d_data[ID_W-1:0];
            // ID 0 means nothing was pending for us: there is nothing to complete.
            state_d = (id_d == '0) ? IDLE : DELIVER;
          end
        end
      end
      DELIVER:   if (int_ready_i) state_d = SERVICE;
      SERVICE:   if (int_done_i) state_d = COMPL_REQ;
      COMPL_REQ: if (tl.tl_i.a_ready) state_d = COMPL_RSP;
      COMPL_RSP: begin
        if (tl.tl_i.d_valid) begin
          err_set = tl.tl_i.d_error;
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
    err_d = err_set | (err_q & ~err_clr_i);
  end

  // Channel A is decoded purely from registered state, so a_valid and its fields
  // stay put for as long as the device withholds a_ready.
  always_comb begin
    tl_h2d = '0;
    unique case (state_q)
      CLAIM_REQ, COMPL_REQ: begin
        tl_h2d.a_valid   = 1'b1;
        tl_h2d.a_opcode  = (state_q == CLAIM_REQ) ? Get : PutFullData;
        tl_h2d.a_size    = 2'd2;
        tl_h2d.a_mask    = 4'hF;
        tl_h2d.a_source  = TL_SRC;
        tl_h2d.a_address = CC_ADDR;
        if (state_q == COMPL_REQ) tl_h2d.a_data = {{(32-ID_W){1'b0}}, id_q};
      end
      CLAIM_RSP, COMPL_RSP: tl_h2d.d_ready = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign tl.tl_o     = tl_h2d;
  assign int_valid_o = (state_q == DELIVER);
  assign int_id_o    = id_q;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

  // Response fields and the PLIC's advertised ID are informational only here.
  logic unused_inputs;
  assign unused_inputs = ^{irq_id_i, tl.tl_i.d_opcode, tl.tl_i.d_param, tl.tl_i.d_size,
                           tl.tl_i.d_source, tl.tl_i.d_sink, tl.tl_i.d_user,
                           tl.tl_i.d_data[31:ID_W]};

endmodule

// File: tb/tb_rv_plic_claim_agent.sv
// Directed bench for rv_plic_claim_agent: the bench plays both the PLIC TL-UL device and the core.
module tb_rv_plic_claim_agent;
  import tlul_pkg::*;

  localparam logic [31:0] CC = 32'h0C20_0004;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic       irq_i = 1'b0;
  logic [6:0] irq_id_i = '0;
  logic       int_ready_i = 1'b0;
  logic       int_done_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic       int_valid_o;
  logic [6:0] int_id_o;
  logic       busy_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  rv_plic_claim_agent_if bus ();

  rv_plic_claim_agent #(
    .CC_ADDR(CC),
    .ID_W   (7),
    .TL_SRC (8'd0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .irq_i      (irq_i),
    .irq_id_i   (irq_id_i),
    .tl         (bus),
    .int_valid_o(int_valid_o),
    .int_id_o   (int_id_o),
    .int_ready_i(int_ready_i),
    .int_done_i (int_done_i),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .err_clr_i  (err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [2:0] op);
    check({tag, ".a_valid"}, bus.tl_o.a_valid, 1'b1);
    check({tag, ".a_opcode"}, bus.tl_o.a_opcode, op);
    check({tag, ".a_address"}, bus.tl_o.a_address, CC);
    check({tag, ".size_mask_src_param_user"},
          {bus.tl_o.a_size, bus.tl_o.a_mask, bus.tl_o.a_source, bus.tl_o.a_param, bus.tl_o.a_user},
          {2'd2, 4'hF, 8'd0, 3'd0, 16'd0});
    check({tag, ".d_ready"}, bus.tl_o.d_ready, 1'b0);
  endtask

  // One-cycle D beat; the agent must be showing d_ready when it arrives.
  task automatic d_resp(input logic [31:0] data, input logic err, input tl_d_op_e op);
    check("rsp.d_ready", bus.tl_o.d_ready, 1'b1);
    check("rsp.a_valid", bus.tl_o.a_valid, 1'b0);
    bus.tl_i.d_valid  = 1'b1;
    bus.tl_i.d_data   = data;
    bus.tl_i.d_error  = err;
    bus.tl_i.d_opcode = op;
    step();
    bus.tl_i.d_valid  = 1'b0;
    bus.tl_i.d_data   = '0;
    bus.tl_i.d_error  = 1'b0;
    bus.tl_i.d_opcode = AccessAck;
  endtask

  // From IDLE: raise irq, see the Get, handshake immediately; ends in CLAIM_RSP.
  task automatic start_claim(input string tag, input logic keep_irq);
    irq_i = 1'b1;
    en_i  = 1'b1;
    bus.tl_i.a_ready = 1'b1;
    step();
    check_a(tag, Get);
    step();
    irq_i = keep_irq;
  endtask

  initial begin
    bus.tl_i = '0;

    // Reset state
    step(2);
    check("rst.busy", busy_o, 1'b0);
    check("rst.int_valid", int_valid_o, 1'b0);
    check("rst.err", err_o, 1'b0);
    check("rst.int_id", int_id_o, 7'h0);
    check("rst.tl_o", bus.tl_o, '0);
    rst_i = 1'b0;
    step();

    // 1: full claim / deliver / service / complete with ID 0x2A
    irq_id_i = 7'h2A;
    start_claim("t1.claim", 1'b0);
    d_resp(32'h0000_002A, 1'b0, AccessAckData);
    check("t1.int_valid", int_valid_o, 1'b1);
    check("t1.int_id", int_id_o, 7'h2A);
    step(5);
    check("t1.int_valid_held", int_valid_o, 1'b1);
    int_ready_i = 1'b1;
    int_done_i  = 1'b1;
    step();
    int_ready_i = 1'b0;
    int_done_i  = 1'b0;
    check("t1.service_no_valid", int_valid_o, 1'b0);
    check("t1.service_busy", busy_o, 1'b1);
    check("t1.done_in_deliver_ignored", bus.tl_o.a_valid, 1'b0);
    step(5);
    check("t1.service_wait", bus.tl_o.a_valid, 1'b0);
    int_done_i = 1'b1;
    step();
    int_done_i = 1'b0;
    check_a("t1.compl", PutFullData);
    check("t1.compl.a_data", bus.tl_o.a_data, 32'h0000_002A);
    step();
    d_resp(32'h0, 1'b0, AccessAck);
    check("t1.idle", busy_o, 1'b0);
    check("t1.idle.tl_o", bus.tl_o, '0);

    // 2: claim returns ID 0 -> straight back to IDLE, no write
    start_claim("t2.claim", 1'b0);
    d_resp(32'h0, 1'b0, AccessAckData);
    check("t2.idle", busy_o, 1'b0);
    check("t2.no_valid", int_valid_o, 1'b0);
    step(3);
    check("t2.no_write", bus.tl_o.a_valid, 1'b0);

    // 3: a_ready withheld 10 cycles on both requests
    bus.tl_i.a_ready = 1'b0;
    irq_i = 1'b1;
    step();
    irq_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_a("t3.claim_stall", Get);
      step();
    end
    bus.tl_i.a_ready = 1'b1;
    check_a("t3.claim_accept", Get);
    step();
    bus.tl_i.a_ready = 1'b0;
    d_resp(32'h0000_0005, 1'b0, AccessAckData);
    check("t3.int_id", int_id_o, 7'h05);
    int_ready_i = 1'b1;
    step();
    int_ready_i = 1'b0;
    int_done_i  = 1'b1;
    step();
    int_done_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_a("t3.compl_stall", PutFullData);
      check("t3.compl_stall.a_data", bus.tl_o.a_data, 32'h0000_0005);
      step();
    end
    bus.tl_i.a_ready = 1'b1;
    step();
    d_resp(32'h0, 1'b0, AccessAck);
    check("t3.idle", busy_o, 1'b0);

    // 4: d_error on claim, then err_o clear and set-over-clear priority
    start_claim("t4.claim", 1'b0);
    d_resp(32'h0000_0011, 1'b1, AccessAckData);
    check("t4.err_set", err_o, 1'b1);
    check("t4.idle", busy_o, 1'b0);
    check("t4.no_deliver", int_valid_o, 1'b0);
    step();
    check("t4.err_sticky", err_o, 1'b1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("t4.err_clr", err_o, 1'b0);
    start_claim("t4.claim2", 1'b0);
    err_clr_i = 1'b1;
    d_resp(32'h0000_0011, 1'b1, AccessAckData);
    err_clr_i = 1'b0;
    check("t4.set_beats_clr", err_o, 1'b1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check("t4.err_clr2", err_o, 1'b0);

    // 5: en_i dropped in SERVICE -> complete still issued, then IDLE holds
    start_claim("t5.claim", 1'b0);
    d_resp(32'h0000_0033, 1'b0, AccessAckData);
    int_ready_i = 1'b1;
    step();
    int_ready_i = 1'b0;
    en_i  = 1'b0;
    irq_i = 1'b1;
    step(2);
    int_done_i = 1'b1;
    step();
    int_done_i = 1'b0;
    check_a("t5.compl", PutFullData);
    check("t5.compl.a_data", bus.tl_o.a_data, 32'h0000_0033);
    step();
    d_resp(32'h0, 1'b0, AccessAck);
    check("t5.idle", busy_o, 1'b0);
    step(5);
    check("t5.hold_idle", busy_o, 1'b0);
    check("t5.hold_no_req", bus.tl_o.a_valid, 1'b0);
    en_i = 1'b1;
    step();
    check_a("t5.reenable_claim", Get);
    step();
    irq_i = 1'b0;
    d_resp(32'h0, 1'b0, AccessAckData);

    // 6: async reset in SERVICE, then a fresh claim
    start_claim("t6.claim", 1'b0);
    d_resp(32'h0000_0044, 1'b0, AccessAckData);
    int_ready_i = 1'b1;
    step();
    int_ready_i = 1'b0;
    check("t6.in_service", busy_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("t6.rst.busy", busy_o, 1'b0);
    check("t6.rst.int_valid", int_valid_o, 1'b0);
    check("t6.rst.int_id", int_id_o, 7'h0);
    check("t6.rst.tl_o", bus.tl_o, '0);
    step();
    rst_i = 1'b0;
    step();
    check("t6.after_rst_idle", busy_o, 1'b0);
    start_claim("t6.fresh_claim", 1'b0);
    d_resp(32'h0, 1'b0, AccessAckData);
    check("t6.idle", busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
